// File: rtl/scu_dsp_dma_resp.sv
// ---------------------------------------------------------------------------
// scu_dsp_dma_resp
//   SCU-side responder for DSP D0-bus DMA. It owns the DSP external pointers
//   RA0 (read) and WA0 (write). It takes one word request at a time from the
//   DSP and runs it on the SCU memory port. It returns read data, an ACK
//   strobe per word and an END strobe per transfer. Both strobes are aligned
//   to the CE_R/CE_F bus phases that the DSP requester samples.
//
//   Optional build macro: SCU_DSP_DMA_TIMEOUT_EN
//     Adds a watchdog on the memory port. If MEM_RDY does not arrive within
//     TIMEOUT CE_R periods, the access is abandoned and DMA_ERR is raised.
//     When the macro is undefined, DMA_ERR is tied to 0.
//
//   Ports
//     CLK, RST_N              clock, async active-low reset
//     CE_R, CE_F              bus-rate rising / falling phase strobes
//     DSO, RA0W, WA0W, DMAW   DSP D1-bus value plus pointer / mode load strobes
//     DMA_REQ/WE/DO/RUN/LAST  DSP word request side
//     DMA_DI, DMA_ACK, DMA_END  responses to the DSP
//     MEM_A/DO/RD/WR, MEM_DI, MEM_RDY  SCU memory port (level request)
//     DMA_ERR                 sticky bus-timeout flag
// ---------------------------------------------------------------------------
module scu_dsp_dma_resp #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [31:0]       DSO,
  input  logic              RA0W,
  input  logic              WA0W,
  input  logic              DMAW,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [31:0]       DMA_DO,
  input  logic              DMA_RUN,
  input  logic              DMA_LAST,
  output logic [31:0]       DMA_DI,
  output logic              DMA_ACK,
  output logic              DMA_END,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [31:0]       MEM_DO,
  input  logic [31:0]       MEM_DI,
  output logic              MEM_RD,
  output logic              MEM_WR,
  input  logic              MEM_RDY,
  output logic              DMA_ERR
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_ACKP    = 3'd2,
    S_WAITREQ = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ra0_q, ra0_d;
  logic [ADDR_W-1:0] wa0_q, wa0_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [2:0]        add_q, add_d;
  logic              hold_q, hold_d;
  logic              we_q, we_d;
  logic              lastq_q, lastq_d;
  logic [31:0]       dma_di_q, dma_di_d;
  logic [31:0]       mem_do_q, mem_do_d;
  logic              ack_q, ack_d;
  logic              end_q, end_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] step;
  logic              wb_en;
  logic              unused_dso;

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  logic [7:0] tcnt_q, tcnt_d;
  logic       err_q, err_d;
  // Set when the current transfer was ended by the watchdog. It suppresses
  // the pointer write-back without touching the sticky error flag.
  logic       tmo_q, tmo_d;
`endif

  // Only DSO[ADDR_W-1:0] and the mode field are consumed.
  assign unused_dso = &{1'b0, DSO};

  // Step in words: ADD=0 -> 0, otherwise 2^(ADD-1).
  always_comb begin
    step = '0;
    if (add_q != 3'd0) step = ADDR_W'(1) << (add_q - 3'd1);
  end

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  assign wb_en = ~hold_q & ~tmo_q;
`else
  assign wb_en = ~hold_q;
`endif

  always_comb begin
    state_d  = state_q;
    ra0_d    = ra0_q;
    wa0_d    = wa0_q;
    ptr_d    = ptr_q;
    mem_a_d  = mem_a_q;
    add_d    = add_q;
    hold_d   = hold_q;
    we_d     = we_q;
    lastq_d  = lastq_q;
    dma_di_d = dma_di_q;
    mem_do_d = mem_do_q;
    ack_d    = ack_q;
    end_d    = end_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Pointer and mode loads come from the DSP on any clock. They are
        // only accepted here, so a DONE write-back can never race them.
        if (RA0W) ra0_d = DSO[ADDR_W-1:0];
        if (WA0W) wa0_d = DSO[ADDR_W-1:0];
        if (DMAW) begin
          add_d  = DSO[17:15];
          hold_d = DSO[14];
`ifdef SCU_DSP_DMA_TIMEOUT_EN
          err_d  = 1'b0;
`endif
        end
        if (CE_R && DMA_REQ && DMA_RUN) begin
          // Direction is frozen here for the whole transfer.
          we_d     = DMA_WE;
          ptr_d    = DMA_WE ? wa0_q : ra0_q;
          mem_a_d  = DMA_WE ? wa0_q : ra0_q;
          mem_rd_d = ~DMA_WE;
          mem_wr_d = DMA_WE;
          mem_do_d = DMA_DO;
          state_d  = S_ACCESS;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
          tcnt_d   = '0;
          tmo_d    = 1'b0;
`endif
        end
      end

      S_ACCESS: begin
        if (CE_R) begin
          if (MEM_RDY) begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            if (!we_q) dma_di_d = MEM_DI;
            ptr_d    = ptr_q + step;
            lastq_d  = DMA_LAST;
            state_d  = S_ACKP;
          end
`ifdef SCU_DSP_DMA_TIMEOUT_EN
          // This CE_R is period tcnt_q+1 without MEM_RDY.
          else if (tcnt_q == 8'(TIMEOUT - 1)) begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            err_d    = 1'b1;
            tmo_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
`endif
        end
      end

      S_ACKP: begin
        // ACK rises on CE_F and falls on the next CE_R. Exactly one CE_R
        // edge therefore samples it high.
        if (CE_F && !ack_q) begin
          ack_d = 1'b1;
        end else if (CE_R && ack_q) begin
          ack_d   = 1'b0;
          state_d = lastq_q ? S_DONE : S_WAITREQ;
        end
      end

      S_WAITREQ: begin
        if (CE_R) begin
          if (DMA_REQ) begin
            mem_a_d  = ptr_q;
            mem_rd_d = ~we_q;
            mem_wr_d = we_q;
            mem_do_d = DMA_DO;
            state_d  = S_ACCESS;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
            tcnt_d   = '0;
`endif
          end else if (!DMA_RUN) begin
            // The DSP aborted the transfer: no END and no write-back.
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        if (CE_R && !end_q) begin
          end_d = 1'b1;
          if (wb_en) begin
            if (we_q) wa0_d = ptr_q;
            else      ra0_d = ptr_q;
          end
        end else if (CE_F && end_q) begin
          end_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      ra0_q    <= '0;
      wa0_q    <= '0;
      ptr_q    <= '0;
      mem_a_q  <= '0;
      add_q    <= '0;
      hold_q   <= 1'b0;
      we_q     <= 1'b0;
      lastq_q  <= 1'b0;
      dma_di_q <= '0;
      mem_do_q <= '0;
      ack_q    <= 1'b0;
      end_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ra0_q    <= ra0_d;
      wa0_q    <= wa0_d;
      ptr_q    <= ptr_d;
      mem_a_q  <= mem_a_d;
      add_q    <= add_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      lastq_q  <= lastq_d;
      dma_di_q <= dma_di_d;
      mem_do_q <= mem_do_d;
      ack_q    <= ack_d;
      end_q    <= end_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
`ifdef SCU_DSP_DMA_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign DMA_DI  = dma_di_q;
  assign DMA_ACK = ack_q;
  assign DMA_END = end_q;
  assign MEM_A   = mem_a_q;
  assign MEM_DO  = mem_do_q;
  assign MEM_RD  = mem_rd_q;
  assign MEM_WR  = mem_wr_q;

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  assign DMA_ERR = err_q;
`else
  // TIMEOUT has no effect without the watchdog. It is still referenced
  // here so that the parameter stays part of the interface in both builds.
  assign DMA_ERR = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_scu_dsp_dma_resp.sv
// Directed bench for scu_dsp_dma_resp. It uses a 4-clock bus phase
// (CE_R on phase 0, CE_F on phase 2), a simple memory responder, a DSP-side
// transfer task and an edge monitor for the ACK/END/ACCESS phase counts.
module tb_scu_dsp_dma_resp;
  localparam int AW = 25;

  logic          CLK, RST_N, CE_R, CE_F;
  logic [31:0]   DSO;
  logic          RA0W, WA0W, DMAW;
  logic          DMA_REQ, DMA_WE, DMA_RUN, DMA_LAST;
  logic [31:0]   DMA_DO, DMA_DI, MEM_DO, MEM_DI;
  logic          DMA_ACK, DMA_END, MEM_RD, MEM_WR, MEM_RDY, DMA_ERR;
  logic [AW-1:0] MEM_A;

  scu_dsp_dma_resp #(.ADDR_W(AW), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .DSO(DSO),
    .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW), .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE),
    .DMA_DO(DMA_DO), .DMA_RUN(DMA_RUN), .DMA_LAST(DMA_LAST), .DMA_DI(DMA_DI),
    .DMA_ACK(DMA_ACK), .DMA_END(DMA_END), .MEM_A(MEM_A), .MEM_DO(MEM_DO),
    .MEM_DI(MEM_DI), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_RDY(MEM_RDY),
    .DMA_ERR(DMA_ERR)
  );

  int checks = 0;
  int failures = 0;
  int rdy_wait = 1;
  bit no_rdy = 0;

  // Monitor counters (written only by the monitor process).
  int ack_pulses = 0, ack_r_edges = 0, end_pulses = 0, end_f_edges = 0, acc_r_edges = 0;

  logic [31:0]   wdata [8];
  logic [31:0]   got_do [8];
  logic [31:0]   got_di [8];
  logic [AW-1:0] got_a [8];
  logic          got_rd [8];
  logic          got_wr [8];

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    int ph;
    ph = 3; CE_R = 0; CE_F = 0;
    forever begin
      @(posedge CLK); #1;
      ph = (ph + 1) % 4;
      CE_R = (ph == 0);
      CE_F = (ph == 2);
    end
  end

  // Memory responder: it raises RDY for the rdy_wait-th CE_R of an access.
  initial begin
    int k;
    k = 0; MEM_RDY = 0;
    forever begin
      @(negedge CLK);
      MEM_RDY = 1'b0;
      if (!(MEM_RD || MEM_WR)) k = 0;
      else if (CE_R) begin
        k++;
        if (k >= rdy_wait && !no_rdy) MEM_RDY = 1'b1;
      end
    end
  end

  // The CE values seen at a negedge belong to the next posedge.
  initial begin
    logic ap, ep;
    ap = 0; ep = 0;
    forever begin
      @(negedge CLK);
      if (CE_R && DMA_ACK) ack_r_edges++;
      if (CE_F && DMA_END) end_f_edges++;
      if (CE_R && (MEM_RD || MEM_WR)) acc_r_edges++;
      if (DMA_ACK && !ap) ack_pulses++;
      if (DMA_END && !ep) end_pulses++;
      ap = DMA_ACK; ep = DMA_END;
    end
  end

  task automatic pulse(input int which, input logic [31:0] v);
    DSO = v;
    if (which == 0) RA0W = 1; else if (which == 1) WA0W = 1; else DMAW = 1;
    @(negedge CLK);
    RA0W = 0; WA0W = 0; DMAW = 0; DSO = 0;
    @(negedge CLK);
  endtask

  // DSP side of one transfer. poke: after each request, try RA0W/WA0W
  // during ACCESS. abort: drop RUN instead of requesting word 1.
  task automatic dsp_xfer(input bit we, input int n, input bit poke, input bit abort,
                          output bit ok);
    int t;
    ok = 1;
    DMA_WE = we; DMA_RUN = 1;
    for (int w = 0; w < n; w++) begin
      if (abort && w == 1) begin
        DMA_RUN = 0;
        repeat (12) @(negedge CLK);
        return;
      end
      DMA_DO = wdata[w]; DMA_LAST = (w == n - 1); DMA_REQ = 1;
      t = 0;
      while (!(MEM_RD || MEM_WR) && t < 200) begin @(negedge CLK); t++; end
      if (t >= 200) begin ok = 0; DMA_REQ = 0; DMA_RUN = 0; return; end
      DMA_REQ = 0;
      DMA_WE = ~we;  // must be ignored mid-transfer
      got_a[w] = MEM_A; got_do[w] = MEM_DO; got_rd[w] = MEM_RD; got_wr[w] = MEM_WR;
      if (poke) begin
        DSO = 32'h3333; RA0W = 1; WA0W = 1;
        @(negedge CLK);
        RA0W = 0; WA0W = 0; DSO = 0;
      end
      t = 0;
      while (!DMA_ACK && t < 200) begin @(negedge CLK); t++; end
      if (t >= 200) begin ok = 0; DMA_RUN = 0; return; end
      got_di[w] = DMA_DI;
      t = 0;
      while (DMA_ACK && t < 200) begin @(negedge CLK); t++; end
    end
    t = 0;
    while (!DMA_END && t < 200) begin @(negedge CLK); t++; end
    if (t >= 200) ok = 0;
    t = 0;
    while (DMA_END && t < 200) begin @(negedge CLK); t++; end
    DMA_RUN = 0; DMA_LAST = 0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++; if (MEM_RD !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", MEM_RD); end
    checks++; if (MEM_WR !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", MEM_WR); end
    checks++; if (DMA_ACK !== 1'b0 || DMA_END !== 1'b0) begin failures++; $display("FAIL reset_ack_end got=%b%b exp=00", DMA_ACK, DMA_END); end
    checks++; if (MEM_A !== '0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", MEM_A); end
    checks++; if (DMA_DI !== 32'h0) begin failures++; $display("FAIL reset_dma_di got=%h exp=0", DMA_DI); end
    checks++; if (DMA_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", DMA_ERR); end
    checks++; if (dut.ra0_q !== '0 || dut.wa0_q !== '0) begin failures++; $display("FAIL reset_ptrs got=%h/%h exp=0/0", dut.ra0_q, dut.wa0_q); end
  endtask

  task automatic test_single_read();
    bit ok; int b_ack, b_ackr, b_end, b_endf, b_acc;
    pulse(0, 32'h100);
    pulse(2, 32'h0000_8000);          // ADD=1, HOLD=0
    MEM_DI = 32'hDEADBEEF; rdy_wait = 3;
    b_ack = ack_pulses; b_ackr = ack_r_edges; b_end = end_pulses; b_endf = end_f_edges; b_acc = acc_r_edges;
    dsp_xfer(0, 1, 0, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd1_timeout got=stall exp=complete"); end
    checks++; if (got_a[0] !== 25'h100 || got_rd[0] !== 1'b1) begin failures++; $display("FAIL rd1_addr got=%h rd=%b exp=100 rd=1", got_a[0], got_rd[0]); end
    checks++; if (got_di[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd1_data got=%h exp=deadbeef", got_di[0]); end
    checks++; if (ack_pulses - b_ack !== 1 || ack_r_edges - b_ackr !== 1) begin failures++; $display("FAIL rd1_ack got=%0d/%0d exp=1/1", ack_pulses - b_ack, ack_r_edges - b_ackr); end
    checks++; if (end_pulses - b_end !== 1 || end_f_edges - b_endf !== 1) begin failures++; $display("FAIL rd1_end got=%0d/%0d exp=1/1", end_pulses - b_end, end_f_edges - b_endf); end
    checks++; if (acc_r_edges - b_acc !== 3) begin failures++; $display("FAIL rd1_wait got=%0d exp=3", acc_r_edges - b_acc); end
    checks++; if (dut.ra0_q !== 25'h101) begin failures++; $display("FAIL rd1_ra0 got=%h exp=101", dut.ra0_q); end
  endtask

  task automatic test_back_to_back_write();
    bit ok; int b_ack, b_end;
    logic [AW-1:0] ea [4];
    ea[0] = 25'h200; ea[1] = 25'h204; ea[2] = 25'h208; ea[3] = 25'h20C;
    pulse(1, 32'h200);
    pulse(2, 32'h0001_8000);          // ADD=3 -> step 4
    for (int i = 0; i < 4; i++) wdata[i] = i + 1;
    rdy_wait = 2;
    b_ack = ack_pulses; b_end = end_pulses;
    dsp_xfer(1, 4, 0, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wr4_timeout got=stall exp=complete"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_a[i] !== ea[i] || got_do[i] !== i + 1 || got_wr[i] !== 1'b1 || got_rd[i] !== 1'b0) begin
        failures++; $display("FAIL wr4_word%0d got=%h/%h wr=%b exp=%h/%h wr=1", i, got_a[i], got_do[i], got_wr[i], ea[i], i + 1);
      end
    end
    checks++; if (ack_pulses - b_ack !== 4 || end_pulses - b_end !== 1) begin failures++; $display("FAIL wr4_strobes got=%0d/%0d exp=4/1", ack_pulses - b_ack, end_pulses - b_end); end
    checks++; if (dut.wa0_q !== 25'h210 || dut.ra0_q !== 25'h101) begin failures++; $display("FAIL wr4_ptrs got=%h/%h exp=210/101", dut.wa0_q, dut.ra0_q); end
  endtask

  task automatic test_hold_read();
    bit ok;
    pulse(0, 32'h50);
    pulse(2, 32'h0001_4000);          // ADD=2, HOLD=1
    MEM_DI = 32'h1234_5678; rdy_wait = 1;
    dsp_xfer(0, 2, 0, 0, ok);
    checks++; if (!ok || got_a[0] !== 25'h50 || got_a[1] !== 25'h52) begin failures++; $display("FAIL hold_addr got=%h,%h exp=50,52", got_a[0], got_a[1]); end
    checks++; if (dut.ra0_q !== 25'h50) begin failures++; $display("FAIL hold_ra0 got=%h exp=50", dut.ra0_q); end
  endtask

  task automatic test_wrap();
    bit ok;
    pulse(0, 32'h01FF_FFFF);
    pulse(2, 32'h0000_8000);
    rdy_wait = 1;
    dsp_xfer(0, 2, 0, 0, ok);
    checks++; if (!ok || got_a[0] !== 25'h1FFFFFF || got_a[1] !== 25'h0) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=1ffffff,0", got_a[0], got_a[1]); end
    checks++; if (dut.ra0_q !== 25'h1) begin failures++; $display("FAIL wrap_ra0 got=%h exp=1", dut.ra0_q); end
  endtask

  task automatic test_load_during_access();
    bit ok;
    pulse(0, 32'h40);
    rdy_wait = 4;
    dsp_xfer(0, 1, 1, 0, ok);
    checks++; if (!ok || got_a[0] !== 25'h40) begin failures++; $display("FAIL poke_addr got=%h exp=40", got_a[0]); end
    checks++; if (dut.ra0_q !== 25'h41 || dut.wa0_q !== 25'h210) begin failures++; $display("FAIL poke_ptrs got=%h/%h exp=41/210", dut.ra0_q, dut.wa0_q); end
  endtask

  task automatic test_abort();
    bit ok; int b_end;
    pulse(0, 32'h80);
    rdy_wait = 1;
    b_end = end_pulses;
    dsp_xfer(0, 2, 0, 1, ok);
    checks++; if (end_pulses - b_end !== 0 || MEM_RD !== 1'b0) begin failures++; $display("FAIL abort_end got=%0d rd=%b exp=0 rd=0", end_pulses - b_end, MEM_RD); end
    checks++; if (dut.ra0_q !== 25'h80) begin failures++; $display("FAIL abort_ra0 got=%h exp=80", dut.ra0_q); end
    pulse(0, 32'h90);                 // accepted only if back in IDLE
    checks++; if (dut.ra0_q !== 25'h90) begin failures++; $display("FAIL abort_idle got=%h exp=90", dut.ra0_q); end
  endtask

`ifdef SCU_DSP_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int t, b_ack, b_end, b_acc;
    pulse(0, 32'h60);
    pulse(2, 32'h0000_8000);
    no_rdy = 1;
    b_ack = ack_pulses; b_end = end_pulses; b_acc = acc_r_edges;
    DMA_WE = 0; DMA_RUN = 1; DMA_LAST = 1; DMA_REQ = 1;
    t = 0; while (!MEM_RD && t < 200) begin @(negedge CLK); t++; end
    DMA_REQ = 0;
    t = 0; while (!DMA_END && t < 200) begin @(negedge CLK); t++; end
    checks++; if (t >= 200 || DMA_ERR !== 1'b1 || MEM_RD !== 1'b0) begin failures++; $display("FAIL tmo_flag got=err%b rd%b exp=err1 rd0", DMA_ERR, MEM_RD); end
    t = 0; while (DMA_END && t < 200) begin @(negedge CLK); t++; end
    DMA_RUN = 0; DMA_LAST = 0; no_rdy = 0;
    repeat (4) @(negedge CLK);
    checks++; if (acc_r_edges - b_acc !== 8) begin failures++; $display("FAIL tmo_periods got=%0d exp=8", acc_r_edges - b_acc); end
    checks++; if (ack_pulses - b_ack !== 0 || end_pulses - b_end !== 1) begin failures++; $display("FAIL tmo_strobes got=%0d/%0d exp=0/1", ack_pulses - b_ack, end_pulses - b_end); end
    checks++; if (dut.ra0_q !== 25'h60 || DMA_ERR !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%h err%b exp=60 err1", dut.ra0_q, DMA_ERR); end
    pulse(2, 32'h0000_8000);
    checks++; if (DMA_ERR !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", DMA_ERR); end
  endtask
`endif

  task automatic test_reset_mid();
    int t;
    pulse(0, 32'h70);
    no_rdy = 1;
    DMA_WE = 0; DMA_RUN = 1; DMA_LAST = 1; DMA_REQ = 1;
    t = 0; while (!MEM_RD && t < 200) begin @(negedge CLK); t++; end
    DMA_REQ = 0;
    checks++; if (MEM_RD !== 1'b1) begin failures++; $display("FAIL rstmid_start got=%b exp=1", MEM_RD); end
    #2 RST_N = 0;
    #1;
    checks++; if (MEM_RD !== 1'b0 || dut.ra0_q !== '0) begin failures++; $display("FAIL rstmid_drop got=rd%b ra0=%h exp=rd0 ra0=0", MEM_RD, dut.ra0_q); end
    DMA_RUN = 0; DMA_LAST = 0; no_rdy = 0;
    @(negedge CLK); RST_N = 1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RST_N = 0; DSO = 0; RA0W = 0; WA0W = 0; DMAW = 0;
    DMA_REQ = 0; DMA_WE = 0; DMA_DO = 0; DMA_RUN = 0; DMA_LAST = 0; MEM_DI = 0;
    for (int i = 0; i < 8; i++) wdata[i] = 0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST_N = 1;
    repeat (2) @(negedge CLK);
    test_single_read();
    test_back_to_back_write();
    test_hold_read();
    test_wrap();
    test_load_during_access();
    test_abort();
`ifdef SCU_DSP_DMA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scu_dsp_dma_resp.md
Name: scu_dsp_dma_resp

Overview:
- SCU-side responder for DSP D0-bus DMA.
- Owns the DSP's external read/write address pointers (RA0/WA0) and accepts word-by-word DMA requests from the DSP.
- Performs each access on the SCU memory port and returns data, ACK and END strobes with the timing the DSP requester samples.
- Sits between the DSP core and the SCU internal bus arbiter.

Parameters:
- ADDR_W, 25, width of word address (byte address = {addr,2'b00}).
- TIMEOUT, 255, maximum CE_R periods to wait for MEM_RDY (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  bus-rate rising-phase strobe.
- CE_F  in  1  bus-rate falling-phase strobe.
- DSO  in  32  DSP D1-bus value.
- RA0W  in  1  load RA0 from DSO.
- WA0W  in  1  load WA0 from DSO.
- DMAW  in  1  DSP DMA instruction word present on DSO; latch mode.
- DMA_REQ  in  1  DSP requests one word.
- DMA_WE  in  1  1 = DSP→memory (write), 0 = memory→DSP (read).
- DMA_DO  in  32  write data from DSP.
- DMA_RUN  in  1  DSP transfer active.
- DMA_LAST  in  1  current word is the final one.
- DMA_DI  out  32  read data to DSP.
- DMA_ACK  out  1  word accepted/delivered.
- DMA_END  out  1  transfer complete.
- MEM_A  out  ADDR_W  memory word address.
- MEM_DO  out  32  memory write data.
- MEM_DI  in  32  memory read data.
- MEM_RD  out  1  read request (level).
- MEM_WR  out  1  write request (level).
- MEM_RDY  in  1  access complete (sampled on CE_R).
- DMA_ERR  out  1  bus timeout flag (optional feature only).

Behaviour:
- Reset: RA0=WA0=0, mode=0, state IDLE. All outputs 0, DMA_DI=0, MEM_A=0.
- RA0W/WA0W (any clock, CE-qualified by the DSP): RA0/WA0 <= DSO[ADDR_W-1:0]. Ignored while state != IDLE.
- DMAW: latch ADD=DSO[17:15] and HOLD=DSO[14]. Step in words = {0,1,2,4,8,16,32,64}[ADD]. Latched only in IDLE.
- Working pointer PTR: loaded on leaving IDLE, from WA0 if DMA_WE else RA0.
- FSM, advances only on CE_R unless noted:
  - IDLE: DMA_REQ & DMA_RUN → ACCESS. MEM_RD = ~DMA_WE, MEM_WR = DMA_WE, MEM_A = PTR, MEM_DO = DMA_DO.
  - ACCESS: hold request. When MEM_RDY is sampled: drop MEM_RD/MEM_WR; on read, DMA_DI <= MEM_DI; PTR <= PTR + step (wraps modulo 2^ADDR_W); capture LASTQ = DMA_LAST → ACKP.
  - ACKP: on next CE_F set DMA_ACK=1. On following CE_R clear DMA_ACK (exactly one CE_R edge sees ACK=1). Then LASTQ ? DONE : WAITREQ.
  - WAITREQ: DMA_REQ → ACCESS with next word, same direction. DMA_RUN low without REQ → IDLE (DSP aborted; no END).
  - DONE: DMA_END=1 on CE_R. Cleared on the first CE_F after that. If HOLD=0, write PTR back to WA0/RA0 (matching direction); if HOLD=1, leave pointer unchanged. → IDLE.
- Latency per word: ≥ 1 CE_R (request) + memory wait + 1 CE_R (ACK).
- Simultaneous RA0W/WA0W with DONE write-back: write-back wins, since RA0W/WA0W are ignored outside IDLE.
- DMA_REQ re-asserted while in ACKP: held until WAITREQ.
- DMA_WE is sampled only when leaving IDLE; changes mid-transfer are ignored.
- Reset mid-transfer: immediate return to reset values. MEM_RD/MEM_WR drop asynchronously.

Optional Feature:
- Macro SCU_DSP_DMA_TIMEOUT_EN.
- Defined: an 8-bit counter counts CE_R periods in ACCESS. When the count reaches TIMEOUT without MEM_RDY: drop the memory request, set DMA_ERR=1 (sticky until reset or next DMAW), go to DONE (END is pulsed, no ACK for that word, no pointer write-back).
- Undefined: no counter; DMA_ERR tied 0; ACCESS waits indefinitely.

Test Plan:
- Single-word read: RA0W with DSO=0x100, DMAW with ADD=1, HOLD=0; REQ with DMA_WE=0, DMA_LAST=1; MEM_DI=0xDEADBEEF, RDY after 3 CE_R → MEM_A=0x100, DMA_DI=0xDEADBEEF, one ACK, one END, RA0=0x101.
- 4-word write with ADD=3 (step 4), WA0=0x200, DO=1,2,3,4 → MEM_A 0x200/0x204/0x208/0x20C with matching data, 4 ACKs, END after the 4th, WA0=0x210.
- HOLD=1 read of 2 words from RA0=0x50, step 2 → MEM_A 0x50, 0x52; RA0 stays 0x50 after END.
- Wrap: RA0=0x1FFFFFF, step 1, 2 words → MEM_A 0x1FFFFFF then 0x0000000.
- Timing: verify ACK is high across exactly one CE_R edge, END is high across exactly one CE_F, and RA0W pulses during ACCESS leave RA0 unchanged.
- With SCU_DSP_DMA_TIMEOUT_EN, TIMEOUT=8, MEM_RDY held 0 → after 8 CE_R: DMA_ERR=1, END pulsed, no ACK, MEM_RD=0.
